// File: rtl/sha1_block_sched.sv
// Block sequencer for the SHA-1 core. It double-buffers one 16-word host block,
// loads and starts the core, chains blocks of a message and holds the digest.
module sha1_block_sched (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_first,
    input  logic         in_last,
    output logic         core_load,
    output logic [31:0]  core_data,
    output logic         core_start,
    output logic [159:0] core_cv,
    output logic         core_use_prev_cv,
    input  logic         core_busy,
    input  logic         core_out_valid,
    input  logic [159:0] core_cv_next,
    output logic         digest_valid,
    output logic [159:0] digest,
    input  logic         digest_ready,
    output logic         busy
);
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] buffer [16];
    logic [4:0]  count;
    logic [3:0]  load_idx;
    logic        buf_first;
    logic        buf_last;
    logic        msg_open;
    logic        blk_last;
    logic        blk_prev;
    logic        first_eff;
    logic        accept;
    logic        capture;

    assign in_ready  = (count < 5'd16) && (state != LOAD);
    assign accept    = in_valid && in_ready;
    assign first_eff = buf_first || !msg_open;
    assign core_cv   = IV;
    assign busy      = (state != IDLE) || (count != 5'd0);
    assign core_data = core_load ? buffer[load_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        core_load        = 1'b0;
        core_start       = 1'b0;
        core_use_prev_cv = 1'b0;
        capture          = 1'b0;
        case (state)
            IDLE: begin
                if ((count == 5'd16) && !core_busy) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                core_load        = 1'b1;
                core_use_prev_cv = !first_eff;
                if (load_idx == 4'd15) begin
                    state_next = START;
                end
            end
            START: begin
                // The buffer may already be refilling, so use the flag latched at LOAD exit.
                core_start       = 1'b1;
                core_use_prev_cv = blk_prev;
                state_next       = WAIT;
            end
            WAIT: begin
                if (core_out_valid) begin
                    if (!blk_last) begin
                        state_next = IDLE;
                    end else if (!digest_valid || digest_ready) begin
                        capture    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!digest_valid || digest_ready) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[count[3:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= 5'd0;
            load_idx     <= 4'd0;
            buf_first    <= 1'b0;
            buf_last     <= 1'b0;
            msg_open     <= 1'b0;
            blk_last     <= 1'b0;
            blk_prev     <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= 160'h0;
        end else begin
            if (accept) begin
                count <= count + 5'd1;
                if (count == 5'd0) begin
                    buf_first <= in_first;
                end
                if (count == 5'd15) begin
                    buf_last <= in_last;
                end
            end
            if (state == LOAD) begin
                load_idx <= load_idx + 4'd1;
                if (load_idx == 4'd15) begin
                    count    <= 5'd0;
                    blk_last <= buf_last;
                    blk_prev <= !first_eff;
                end
            end
            if (core_start) begin
                msg_open <= 1'b1;
            end
            // A capture wins over the host draining the previous digest.
            if (capture) begin
                digest       <= core_cv_next;
                digest_valid <= 1'b1;
                msg_open     <= 1'b0;
            end else if (digest_valid && digest_ready) begin
                digest_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sha1_block_sched.sv
// Bench for sha1_block_sched with a behavioural 82-cycle SHA-1 core model and a
// digest scoreboard checked against published SHA-1 test vectors.
module tb_sha1_block_sched;
    localparam logic [159:0] IV        = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] DIG_ABC   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
    localparam logic [159:0] DIG_EMPTY = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;
    localparam logic [159:0] DIG_TWO   = 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'h0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         core_load;
    logic [31:0]  core_data;
    logic         core_start;
    logic [159:0] core_cv;
    logic         core_use_prev_cv;
    logic         core_busy;
    logic         core_out_valid;
    logic [159:0] core_cv_next;
    logic         digest_valid;
    logic [159:0] digest;
    logic         digest_ready = 1'b0;
    logic         busy;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int load_cyc_q[$];
    int cov_q[$];
    logic prev_q[$];
    logic [159:0] sb_q[$];
    logic load_prev = 1'b0;
    logic [31:0] blk [16];

    logic [511:0] core_w;
    logic [159:0] core_pending;
    int           core_cnt;

    sha1_block_sched dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_last(in_last),
        .core_load(core_load), .core_data(core_data), .core_start(core_start),
        .core_cv(core_cv), .core_use_prev_cv(core_use_prev_cv),
        .core_busy(core_busy), .core_out_valid(core_out_valid), .core_cv_next(core_cv_next),
        .digest_valid(digest_valid), .digest(digest), .digest_ready(digest_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [159:0] sha1_compress(input logic [159:0] cv, input logic [511:0] b);
        logic [31:0] w [80];
        logic [31:0] a, bb, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, bb, c, d, e} = cv;
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin f = (bb & c) | (~bb & d); k = 32'h5A827999; end
            else if (i < 40) begin f = bb ^ c ^ d; k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8F1BBCDC; end
            else begin f = bb ^ c ^ d; k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
        end
        return {cv[159:128] + a, cv[127:96] + bb, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
    endfunction

    // Core model: out_valid exactly 82 cycles after the start cycle, busy in between.
    always @(posedge clk) begin
        if (reset) begin
            core_busy      <= 1'b0;
            core_out_valid <= 1'b0;
            core_cv_next   <= 160'h0;
            core_cnt       <= 0;
            core_w         <= 512'h0;
            core_pending   <= 160'h0;
        end else begin
            core_out_valid <= 1'b0;
            if (core_load) core_w <= {core_w[479:0], core_data};
            if (core_start) begin
                core_busy    <= 1'b1;
                core_cnt     <= 81;
                core_pending <= sha1_compress(core_use_prev_cv ? core_cv_next : core_cv, core_w);
            end else if (core_out_valid) begin
                core_busy <= 1'b0;
            end else if (core_busy) begin
                if (core_cnt == 1) begin
                    core_out_valid <= 1'b1;
                    core_cv_next   <= core_pending;
                end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Event log and digest scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (core_load && !load_prev) begin
            load_cyc_q.push_back(cyc);
            prev_q.push_back(core_use_prev_cv);
        end
        load_prev = core_load;
        if (core_out_valid) cov_q.push_back(cyc);
        if (core_start) begin
            start_cyc = cyc;
            checks++;
            if (core_busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL start_while_busy: core_busy=%b required 0", core_busy);
            end
        end
        if (digest_valid && digest_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_digest: got %h with no digest outstanding", digest);
            end else begin
                logic [159:0] exp_dig;
                exp_dig = sb_q.pop_front();
                if (digest !== exp_dig) begin
                    fails++;
                    $display("[TB] FAIL digest: got %h required %h", digest, exp_dig);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_empty();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0] = 32'h80000000;
    endtask

    task automatic set_two1();
        blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566; blk[3]  = 32'h64656667;
        blk[4]  = 32'h65666768; blk[5]  = 32'h66676869; blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b;
        blk[8]  = 32'h696a6b6c; blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
        blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000; blk[15] = 32'h00000000;
    endtask

    task automatic set_two2();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[15] = 32'h000001C0;
    endtask

    // Streams blk[] gaplessly while in_ready allows; returns the cycle word 0 was taken.
    task automatic send_block(input logic first, input logic last, output int c_first);
        bit done;
        int tries;
        c_first = 0;
        for (int i = 0; i < 16; i++) begin
            done = 0;
            tries = 0;
            in_valid = 1'b1;
            in_data  = blk[i];
            in_first = (i == 0) ? first : 1'b0;
            in_last  = (i == 15) ? last : 1'b0;
            while (!done && tries < 500) begin
                @(negedge clk);
                if (in_ready) begin
                    done = 1;
                    if (i == 0) c_first = cyc;
                end
                @(posedge clk); #1;
                tries++;
            end
            if (!done) begin
                checks++; fails++;
                $display("[TB] FAIL word_accept: word %0d not accepted, got timeout required acceptance", i);
            end
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
        if (core_load !== 1'b0) begin fails++; $display("[TB] FAIL reset_core_load: got %b required 0", core_load); end
        if (core_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_core_start: got %b required 0", core_start); end
        if (core_use_prev_cv !== 1'b0) begin fails++; $display("[TB] FAIL reset_use_prev: got %b required 0", core_use_prev_cv); end
        if (digest_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_digest_valid: got %b required 0", digest_valid); end
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        if (digest !== 160'h0) begin fails++; $display("[TB] FAIL reset_digest: got %h required 0", digest); end
        if (core_cv !== IV) begin fails++; $display("[TB] FAIL reset_core_cv: got %h required %h", core_cv, IV); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_abc_timing();
        int c0;
        int cv;
        bit seen;
        load_cyc_q.delete(); cov_q.delete(); prev_q.delete();
        set_abc();
        digest_ready = 1'b1;
        sb_q.push_back(DIG_ABC);
        send_block(1'b1, 1'b1, c0);
        seen = 0; cv = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (digest_valid) begin seen = 1; cv = cyc; end
        end
        checks += 4;
        if (!seen || (cv - c0) != 116) begin fails++; $display("[TB] FAIL abc_digest_cycle: got %0d required 116", cv - c0); end
        if (load_cyc_q.size() < 1 || (load_cyc_q[0] - c0) != 17) begin fails++; $display("[TB] FAIL abc_load_cycle: got %0d required 17", (load_cyc_q.size() > 0) ? load_cyc_q[0] - c0 : -1); end
        if ((start_cyc - c0) != 33) begin fails++; $display("[TB] FAIL abc_start_cycle: got %0d required 33", start_cyc - c0); end
        if (cov_q.size() < 1 || (cov_q[0] - c0) != 115) begin fails++; $display("[TB] FAIL abc_out_valid_cycle: got %0d required 115", (cov_q.size() > 0) ? cov_q[0] - c0 : -1); end
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks += 2;
        if (sb_q.size() != 0) begin fails++; $display("[TB] FAIL abc_drain: got %0d outstanding required 0", sb_q.size()); end
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abc_idle_busy: got %b required 0", busy); end
        @(posedge clk); #1;
        digest_ready = 1'b0;
    endtask

    task automatic test_two_block();
        int c0;
        int c1;
        bit seen;
        load_cyc_q.delete(); cov_q.delete(); prev_q.delete();
        digest_ready = 1'b1;
        sb_q.push_back(DIG_TWO);
        set_two1();
        send_block(1'b1, 1'b0, c0);
        set_two2();
        send_block(1'b0, 1'b1, c1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL two_ready_full: got %b required 0", in_ready); end
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (core_load) seen = 1;
        end
        checks++;
        if (!seen || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL two_ready_load: got %b seen %0d required 0", in_ready, seen); end
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (core_start) seen = 1;
        end
        checks++;
        if (!seen || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL two_ready_start: got %b seen %0d required 1", in_ready, seen); end
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        checks += 5;
        if (sb_q.size() != 0) begin fails++; $display("[TB] FAIL two_drain: got %0d outstanding required 0", sb_q.size()); end
        if (prev_q.size() != 2 || prev_q[0] !== 1'b0) begin fails++; $display("[TB] FAIL two_prev_blk1: got %b (n=%0d) required 0", (prev_q.size() > 0) ? prev_q[0] : 1'bx, prev_q.size()); end
        if (prev_q.size() != 2 || prev_q[1] !== 1'b1) begin fails++; $display("[TB] FAIL two_prev_blk2: got %b (n=%0d) required 1", (prev_q.size() > 1) ? prev_q[1] : 1'bx, prev_q.size()); end
        if (load_cyc_q.size() != 2 || cov_q.size() < 1 || (load_cyc_q[1] - cov_q[0]) != 2) begin fails++; $display("[TB] FAIL two_load_after_cov: got %0d required 2", (load_cyc_q.size() > 1 && cov_q.size() > 0) ? load_cyc_q[1] - cov_q[0] : -1); end
        if (load_cyc_q.size() != 2 || (load_cyc_q[1] - load_cyc_q[0]) != 100) begin fails++; $display("[TB] FAIL two_block_period: got %0d required 100", (load_cyc_q.size() > 1) ? load_cyc_q[1] - load_cyc_q[0] : -1); end
        @(posedge clk); #1;
        digest_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c0;
        load_cyc_q.delete(); cov_q.delete(); prev_q.delete();
        digest_ready = 1'b0;
        sb_q.push_back(DIG_ABC);
        sb_q.push_back(DIG_EMPTY);
        set_abc();
        send_block(1'b1, 1'b1, c0);
        set_empty();
        send_block(1'b1, 1'b1, c0);
        for (int i = 0; i < 400 && cov_q.size() < 2; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks += 5;
        if (cov_q.size() != 2) begin fails++; $display("[TB] FAIL b2b_completions: got %0d required 2", cov_q.size()); end
        if (busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_hold_busy: got %b required 1", busy); end
        if (digest_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_hold_valid: got %b required 1", digest_valid); end
        if (digest !== DIG_ABC) begin fails++; $display("[TB] FAIL b2b_hold_digest: got %h required %h", digest, DIG_ABC); end
        if (core_busy !== 1'b0) begin fails++; $display("[TB] FAIL b2b_core_idle: got %b required 0", core_busy); end
        @(posedge clk); #1;
        digest_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        digest_ready = 1'b0;
        @(negedge clk);
        checks += 3;
        if (sb_q.size() != 0) begin fails++; $display("[TB] FAIL b2b_drain: got %0d outstanding required 0", sb_q.size()); end
        if (digest_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_valid_after: got %b required 0", digest_valid); end
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL b2b_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_first_missing();
        int c0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        load_cyc_q.delete(); cov_q.delete(); prev_q.delete();
        digest_ready = 1'b1;
        sb_q.push_back(DIG_ABC);
        set_abc();
        send_block(1'b0, 1'b1, c0);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        checks += 2;
        if (sb_q.size() != 0) begin fails++; $display("[TB] FAIL nofirst_drain: got %0d outstanding required 0", sb_q.size()); end
        if (prev_q.size() != 1 || prev_q[0] !== 1'b0) begin fails++; $display("[TB] FAIL nofirst_use_prev: got %b (n=%0d) required 0", (prev_q.size() > 0) ? prev_q[0] : 1'bx, prev_q.size()); end
        @(posedge clk); #1;
        digest_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int c0;
        bit seen;
        digest_ready = 1'b0;
        set_abc();
        send_block(1'b1, 1'b1, c0);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (digest_valid) seen = 1;
        end
        checks++;
        if (!seen || digest !== DIG_ABC) begin fails++; $display("[TB] FAIL rst_pending_digest: got %h required %h", digest, DIG_ABC); end
        send_block(1'b1, 1'b1, c0);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (core_start) seen = 1;
        end
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h61626380; in_first = 1'b1;
        @(posedge clk); #1;
        in_first = 1'b0; in_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks += 5;
        if (digest_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_digest_valid: got %b required 0", digest_valid); end
        if (digest !== 160'h0) begin fails++; $display("[TB] FAIL rst_digest: got %h required 0", digest); end
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready: got %b required 1", in_ready); end
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        if (core_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_core_start: got %b required 0", core_start); end
        @(posedge clk); #1;
        digest_ready = 1'b1;
        sb_q.push_back(DIG_ABC);
        set_abc();
        send_block(1'b1, 1'b1, c0);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin fails++; $display("[TB] FAIL rst_after_drain: got %0d outstanding required 0", sb_q.size()); end
        @(posedge clk); #1;
        digest_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_abc_timing();
        test_two_block();
        test_back_to_back();
        test_first_missing();
        test_reset_mid_wait();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
